// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults, count-width helper and data word type for the programmable FIFO
// Contents:
//   DATA_W_DEF / DEPTH_DEF  default word width and entry count
//   cnt_w()                 width needed to hold an occupancy of 0..depth
//   word_t                  data word at the default width
package fifo_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 16;

    // One extra bit over the address width so that DEPTH itself is representable.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef logic [DATA_W_DEF-1:0] word_t;

endpackage

// File: rtl/fifo_prog_sync_if.sv
// rtl/fifo_prog_sync_if.sv - request/status bundle between a FIFO user and fifo_prog_sync
// Signals:
//   i_wren, i_wrdata, i_rden          write/read requests (user -> FIFO)
//   i_afull_thr, i_aempty_thr         live almost-full / almost-empty thresholds
//   i_clr_err                         clears sticky error flags
//   o_rddata                          read data (FIFO -> user)
//   o_full, o_alm_full, o_empty, o_alm_empty, o_count, o_ovf, o_udf  status
// Modports: master = FIFO user, slave = FIFO.
interface fifo_prog_sync_if #(
    parameter int DATA_W = fifo_pkg::DATA_W_DEF,
    parameter int DEPTH  = fifo_pkg::DEPTH_DEF
) ();
    localparam int CNT_W = fifo_pkg::cnt_w(DEPTH);

    logic              i_wren;
    logic [DATA_W-1:0] i_wrdata;
    logic              i_rden;
    logic [CNT_W-1:0]  i_afull_thr;
    logic [CNT_W-1:0]  i_aempty_thr;
    logic              i_clr_err;
    logic [DATA_W-1:0] o_rddata;
    logic              o_full;
    logic              o_alm_full;
    logic              o_empty;
    logic              o_alm_empty;
    logic [CNT_W-1:0]  o_count;
    logic              o_ovf;
    logic              o_udf;

    modport master (
        output i_wren, i_wrdata, i_rden, i_afull_thr, i_aempty_thr, i_clr_err,
        input  o_rddata, o_full, o_alm_full, o_empty, o_alm_empty, o_count, o_ovf, o_udf
    );

    modport slave (
        input  i_wren, i_wrdata, i_rden, i_afull_thr, i_aempty_thr, i_clr_err,
        output o_rddata, o_full, o_alm_full, o_empty, o_alm_empty, o_count, o_ovf, o_udf
    );

endinterface

// File: rtl/fifo_mem_2p.sv
// rtl/fifo_mem_2p.sv - FIFO storage: register array, one synchronous write port, one asynchronous read port
// Ports:
//   clk_i     write clock
//   we_i      write enable
//   waddr_i   write address
//   wdata_i   write data
//   raddr_i   read address (combinational read)
//   rdata_o   read data
// The array carries no reset; stale contents are never observable because
// the pointer/count logic in the parent only exposes written entries.
module fifo_mem_2p #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_prog_sync.sv
// rtl/fifo_prog_sync.sv - synchronous FIFO with programmable almost-full/empty flags and sticky error flags
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   fifo_prog_sync_if.slave: requests, thresholds, read data, status
// Parameters: DATA_W word width, DEPTH entries (power of 2, >= 4),
//             FWFT 0 = registered read, 1 = first-word-fall-through.
module fifo_prog_sync
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter bit FWFT   = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    fifo_prog_sync_if.slave bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              full, empty;
    logic              wr_acc, rd_acc;
    logic [DATA_W-1:0] mem_rdata;

    // Flags decode straight from the registered count: no extra latency.
    assign full   = (count_q == CNT_W'(DEPTH));
    assign empty  = (count_q == '0);

    // Full blocks writes even when a read is accepted on the same edge.
    assign wr_acc = bus.i_wren & ~full;
    assign rd_acc = bus.i_rden & ~empty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr_acc) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (rd_acc) begin
            rptr_d = rptr_q + AW'(1);
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // Set takes priority over clear so a same-edge error is never lost.
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (bus.i_clr_err) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (bus.i_wren && full) begin
            ovf_d = 1'b1;
        end
        if (bus.i_rden && empty) begin
            udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    fifo_mem_2p #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (wr_acc),
        .waddr_i (wptr_q),
        .wdata_i (bus.i_wrdata),
        .raddr_i (rptr_q),
        .rdata_o (mem_rdata)
    );

    generate
        if (FWFT) begin : g_fwft
            // Head entry is read combinationally; forced to zero while empty so
            // the output is deterministic out of reset.
            assign bus.o_rddata = empty ? '0 : mem_rdata;
        end else begin : g_reg
            logic [DATA_W-1:0] rddata_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rddata_q <= '0;
                end else if (rd_acc) begin
                    rddata_q <= mem_rdata;
                end
            end

            assign bus.o_rddata = rddata_q;
        end
    endgenerate

    assign bus.o_full      = full;
    assign bus.o_empty     = empty;
    assign bus.o_alm_full  = (count_q >= bus.i_afull_thr);
    assign bus.o_alm_empty = (count_q <= bus.i_aempty_thr);
    assign bus.o_count     = count_q;
    assign bus.o_ovf       = ovf_q;
    assign bus.o_udf       = udf_q;

endmodule

// File: doc/fifo_prog_sync.md
FIFO_PROG_SYNC -- requirements
Module: fifo_prog_sync

Interface
REQ-001 The block SHALL have the parameter DATA_W, default 8, giving the data word width in bits.
REQ-002 The block SHALL have the parameter DEPTH, default 16, giving the number of entries; it is a power of 2 and at least 4; CNT_W = $clog2(DEPTH)+1.
REQ-003 The block SHALL have the parameter FWFT, default 0, where 0 selects standard registered read and 1 selects first-word-fall-through.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
- clk  in  1  the only clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- i_wren  in  1  write request.
- i_wrdata  in  DATA_W  write data.
- i_rden  in  1  read/pop request.
- o_rddata  out  DATA_W  read data.
- i_afull_thr  in  CNT_W  almost-full threshold, live.
- i_aempty_thr  in  CNT_W  almost-empty threshold, live.
- i_clr_err  in  1  clears the sticky error flags.
- o_full, o_alm_full, o_empty, o_alm_empty  out  1 each  status flags.
- o_count  out  CNT_W  current occupancy, 0..DEPTH.
- o_ovf, o_udf  out  1 each  sticky overflow/underflow.

Function
REQ-005 A write SHALL be accepted iff i_wren=1 and o_full=0, storing i_wrdata at the write pointer on that edge; a simultaneous read never makes room for a write on a full FIFO.
REQ-006 A read SHALL be accepted iff i_rden=1 and o_empty=0, advancing the read pointer on that edge.
REQ-007 The pointers SHALL wrap modulo DEPTH; there is no other wrap handling.
REQ-008 o_count SHALL update on the edge of an accepted operation: +1 for a write only, -1 for a read only, unchanged when both or neither are accepted.
REQ-009 The flags SHALL be decoded from the registered count with no extra latency:
- o_full = (count==DEPTH).
- o_empty = (count==0).
- o_alm_full = (count >= i_afull_thr).
- o_alm_empty = (count <= i_aempty_thr).
REQ-010 The threshold inputs SHALL have these boundary behaviours:
- i_afull_thr=0 asserts o_alm_full permanently.
- i_afull_thr>DEPTH never asserts o_alm_full.
- i_aempty_thr>=DEPTH asserts o_alm_empty permanently.
REQ-011 In FWFT=0, o_rddata SHALL be registered, present the popped word the cycle after the accepted read, and hold its value otherwise.
REQ-012 In FWFT=1, o_rddata SHALL show the head entry whenever o_empty=0, with the head visible from the cycle after the accepted write to an empty FIFO; an accepted read shows the next entry the following cycle; the value is don't-care while empty.
REQ-013 o_ovf SHALL set on any edge with i_wren=1 and o_full=1.
REQ-014 o_udf SHALL set on any edge with i_rden=1 and o_empty=1.
REQ-015 Both error flags SHALL stay set until i_clr_err=1; when set and clear occur on the same edge, set wins.
REQ-016 For simultaneous events:
- Empty with both requests: the write SHALL be accepted, the read rejected, and o_udf set.
- Full with both requests: the read SHALL be accepted, the write rejected, and o_ovf set.

Reset
REQ-017 rst=1 SHALL immediately, without waiting for clk, force the following state:
- pointers = 0 and o_count = 0.
- o_empty = 1 and o_full = 0.
- o_ovf = 0 and o_udf = 0.
- o_rddata = 0.
- o_alm_full and o_alm_empty follow REQ-009 with count 0.
REQ-018 Reset asserted mid-operation SHALL discard all stored data, and no accepted operation completes on the edge where rst=1.
REQ-019 The storage array SHALL NOT be reset.
REQ-020 After rst deasserts, the first accepted write SHALL be the first word read.

Structure
REQ-021 The shared package fifo_pkg SHALL hold the DATA_W and DEPTH defaults, the count-width function, and a typedef for the data word.
REQ-022 The storage SHALL be the sub-module fifo_mem_2p: a register array with one synchronous write port and one asynchronous read port, with no reset.
REQ-023 The pointers, count, flags and errors SHALL live in fifo_prog_sync.

Verification
REQ-024 Fill/drain, DEPTH=16, FWFT=0: write 0x00..0x0F with reads idle, then read 16 times.
- After write 16: o_full=1 and o_count=16.
- Read data SHALL be 0x00..0x0F in order.
- After the last read: o_empty=1.
REQ-025 Overflow/clear: on a full FIFO drive i_wren=1 with 0xAA.
- The data SHALL be dropped, o_count stays 16 and o_ovf=1.
- o_ovf SHALL stay 1 until i_clr_err pulses.
- Clear plus a new overflow on the same edge SHALL leave o_ovf=1.
REQ-026 Simultaneous requests:
- Empty FIFO, write 0x55 and read together: o_count=1 and o_udf=1.
- Count=8, both requests: o_count stays 8 and data order is preserved.
REQ-027 Thresholds: i_afull_thr=12, i_aempty_thr=3.
- o_alm_empty SHALL be 1 for counts 0..3 and 0 at count 4.
- o_alm_full SHALL be 1 from count 12.
- i_afull_thr=17 SHALL never assert o_alm_full.
REQ-028 FWFT=1: write 0x11 into an empty FIFO.
- o_empty=0 and o_rddata=0x11 the next cycle with no read issued.
- Pop: o_rddata SHALL show the next entry, 0x22, the following cycle.
REQ-029 Reset at count 9 mid-burst: asserting rst asynchronously between edges SHALL immediately give o_count=0 and o_empty=1; after release, write 0x77 then read returns 0x77.
